// File: rtl/logic_pll_reset_sequencer.sv
// Releases a bank of active-low resets one by one, STEP_DELAY_NS apart,
// once the PLL lock has been stable for LOCK_STABLE_NS; any lock loss or request restarts.
module logic_pll_reset_sequencer #(
  parameter int unsigned CLOCK_FREQUENCY_HZ = 100_000_000,
  parameter int unsigned OUTPUTS            = 4,
  parameter int unsigned LOCK_STABLE_NS     = 10_000,
  parameter int unsigned STEP_DELAY_NS      = 1_000
) (
  input  logic               aclk,
  input  logic               areset_n,
  input  logic               locked,
  input  logic               request,
  output logic [OUTPUTS-1:0] reset_n,
  output logic               ready
);

  localparam longint unsigned NS_PER_S   = 64'd1_000_000_000;
  localparam longint unsigned STABLE_RAW =
    (64'(LOCK_STABLE_NS) * 64'(CLOCK_FREQUENCY_HZ) + NS_PER_S - 64'd1) / NS_PER_S;
  localparam longint unsigned STEP_RAW   =
    (64'(STEP_DELAY_NS) * 64'(CLOCK_FREQUENCY_HZ) + NS_PER_S - 64'd1) / NS_PER_S;
  localparam int unsigned STABLE_CYCLES = (STABLE_RAW == 64'd0) ? 1 : 32'(STABLE_RAW);
  localparam int unsigned STEP_CYCLES   = (STEP_RAW == 64'd0) ? 1 : 32'(STEP_RAW);
  localparam int unsigned MAX_CYCLES    = (STABLE_CYCLES > STEP_CYCLES) ? STABLE_CYCLES : STEP_CYCLES;
  localparam int unsigned CNT_W         = $clog2(MAX_CYCLES + 1);
  localparam int unsigned IDX_W         = $clog2(OUTPUTS + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    READY     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [OUTPUTS-1:0] reset_n_d;
  logic               ready_d;
  logic [1:0]         sync;
  logic               run;
  logic               ok;

  // Deassertion of areset_n is synchronized; assertion stays asynchronous.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) sync <= 2'b00;
    else           sync <= {sync[0], 1'b1};
  end

  assign run = sync[1];
  assign ok  = locked & ~request;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      reset_n <= '0;
      ready   <= 1'b0;
    end else if (run) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      reset_n <= reset_n_d;
      ready   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    reset_n_d = reset_n;
    ready_d   = ready;

    case (state_q)
      WAIT_LOCK: begin
        reset_n_d = '0;
        ready_d   = 1'b0;
        cnt_d     = '0;
        idx_d     = '0;
        if (ok) begin
          if (STABLE_CYCLES == 1) begin
            state_d = RELEASE;
          end else begin
            state_d = STABLE;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      STABLE: begin
        if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
          // Shift in one more released bit, lowest index first.
          reset_n_d = OUTPUTS'({reset_n, 1'b1});
          cnt_d     = '0;
          idx_d     = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(OUTPUTS - 1)) state_d = READY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READY: begin
        reset_n_d = '1;
        ready_d   = 1'b1;
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Lock loss or a re-run request drops every reset at once.
    if (state_q != WAIT_LOCK && !ok) begin
      state_d   = WAIT_LOCK;
      cnt_d     = '0;
      idx_d     = '0;
      reset_n_d = '0;
      ready_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_pll_reset_sequencer.sv
// Bench for logic_pll_reset_sequencer: directed scenarios plus random lock/request/reset
// traffic, checked against a model driven by the length of the current clean-lock streak.
module tb_logic_pll_reset_sequencer;

  localparam int S = 5;
  localparam int T = 3;

  logic       aclk;
  logic       areset_n;
  logic       locked;
  logic       request;
  logic [2:0] rst3;
  logic       rdy3;
  logic [0:0] rst1;
  logic       rdy1;

  int errors;
  int checks;
  int e_n;
  int since;
  int streak;

  logic_pll_reset_sequencer #(
    .CLOCK_FREQUENCY_HZ(100_000_000), .OUTPUTS(3), .LOCK_STABLE_NS(50), .STEP_DELAY_NS(30)
  ) dut3 (
    .aclk(aclk), .areset_n(areset_n), .locked(locked), .request(request),
    .reset_n(rst3), .ready(rdy3)
  );

  logic_pll_reset_sequencer #(
    .CLOCK_FREQUENCY_HZ(100_000_000), .OUTPUTS(1), .LOCK_STABLE_NS(50), .STEP_DELAY_NS(30)
  ) dut1 (
    .aclk(aclk), .areset_n(areset_n), .locked(locked), .request(request),
    .reset_n(rst1), .ready(rdy1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e_n, got, exp);
    end
  endtask

  // Streak L = consecutive running edges with locked=1, request=0; E0 is its first edge.
  function automatic int exp_mask(input int l, input int n);
    int p;
    int k;
    if (l == 0) return 0;
    p = l - 1;
    if (p < S - 1 + T) return 0;
    k = (p - (S - 1)) / T;
    if (k > n) k = n;
    return (1 << k) - 1;
  endfunction

  function automatic int exp_ready(input int l, input int n);
    if (l == 0) return 0;
    return ((l - 1) >= (S - 1 + n * T + 1)) ? 1 : 0;
  endfunction

  task automatic check_all(input string pfx);
    check({pfx, "_rst3"}, 32'(rst3), 32'(exp_mask(streak, 3)));
    check({pfx, "_rdy3"}, 32'(rdy3), 32'(exp_ready(streak, 3)));
    check({pfx, "_rst1"}, 32'(rst1), 32'(exp_mask(streak, 1)));
    check({pfx, "_rdy1"}, 32'(rdy1), 32'(exp_ready(streak, 1)));
  endtask

  // Called at a negedge; drives one cycle, optionally pulsing areset_n in the low phase.
  task automatic step(input logic lk, input logic rq, input bit pulse);
    locked  = lk;
    request = rq;
    if (pulse) begin
      #1 areset_n = 1'b0;
      #1;
      check("async_rst3", 32'(rst3), 32'd0);
      check("async_rdy3", 32'(rdy3), 32'd0);
      check("async_rst1", 32'(rst1), 32'd0);
      since  = 0;
      streak = 0;
      #1 areset_n = 1'b1;
    end
    @(posedge aclk);
    e_n++;
    if (!areset_n) begin
      since  = 0;
      streak = 0;
    end else begin
      if (since < 3) since++;
      if (since >= 3) streak = (lk && !rq) ? streak + 1 : 0;
    end
    @(negedge aclk);
    check_all("model");
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    locked   = 1'b0;
    request  = 1'b0;
    #1;
    check("rst_rst3", 32'(rst3), 32'd0);
    check("rst_rdy3", 32'(rdy3), 32'd0);
    since  = 0;
    streak = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    areset_n = 1'b1;
    e_n = 0;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    e_n      = 0;
    since    = 0;
    streak   = 0;
    areset_n = 1'b0;
    locked   = 1'b0;
    request  = 1'b0;
    @(negedge aclk);

    // Nominal sequencing, then lock loss in READY and recovery.
    do_reset();
    for (int e = 1; e <= 55; e++) begin
      step((e >= 10 && e < 40) || e >= 45, 1'b0, 1'b0);
      case (e_n)
        16: check("nom_pre", 32'(rst3), 32'd0);
        17: begin
          check("nom_r0", 32'(rst3), 32'd1);
          check("one_r0", 32'(rst1), 32'd1);
          check("one_rdy_pre", 32'(rdy1), 32'd0);
        end
        18: check("one_rdy", 32'(rdy1), 32'd1);
        20: check("nom_r1", 32'(rst3), 32'd3);
        23: begin
          check("nom_r2", 32'(rst3), 32'd7);
          check("nom_rdy_pre", 32'(rdy3), 32'd0);
        end
        24: check("nom_rdy", 32'(rdy3), 32'd1);
        40: begin
          check("loss_rst", 32'(rst3), 32'd0);
          check("loss_rdy", 32'(rdy3), 32'd0);
        end
        51: check("relock_pre", 32'(rst3), 32'd0);
        52: check("relock_r0", 32'(rst3), 32'd1);
        default: ;
      endcase
    end

    // Lock glitch during STABLE.
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      step(e >= 10 && e != 12, 1'b0, 1'b0);
      case (e_n)
        19: check("glitch_pre", 32'(rst3), 32'd0);
        20: check("glitch_r0", 32'(rst3), 32'd1);
        26: check("glitch_rdy_pre", 32'(rdy3), 32'd0);
        27: check("glitch_rdy", 32'(rdy3), 32'd1);
        default: ;
      endcase
    end

    // Request during RELEASE.
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      step(e >= 10, e == 18 || e == 19, 1'b0);
      case (e_n)
        17: check("req_r0_before", 32'(rst3), 32'd1);
        18: check("req_abort", 32'(rst3), 32'd0);
        26: check("req_pre", 32'(rst3), 32'd0);
        27: check("req_r0", 32'(rst3), 32'd1);
        default: ;
      endcase
    end

    // Asynchronous reset mid-sequence.
    do_reset();
    for (int e = 1; e <= 35; e++) begin
      step(e >= 10, 1'b0, e == 22);
      case (e_n)
        21: check("arst_before", 32'(rst3), 32'd3);
        30: check("arst_pre", 32'(rst3), 32'd0);
        31: check("arst_r0", 32'(rst3), 32'd1);
        default: ;
      endcase
    end

    // Random lock drops, requests and reset pulses.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 39) != 0, $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_pll_reset_sequencer.md
LOGIC_PLL_RESET_SEQUENCER -- requirements
Module: logic_pll_reset_sequencer

Interface
REQ-001 The module SHALL have parameter CLOCK_FREQUENCY_HZ, default 100_000_000, aclk frequency in Hz.
REQ-002 The module SHALL have parameter OUTPUTS, default 4, number of sequenced reset outputs; legal range 1 or more.
REQ-003 The module SHALL have parameter LOCK_STABLE_NS, default 10_000, time locked must stay high before sequencing starts.
REQ-004 The module SHALL have parameter STEP_DELAY_NS, default 1_000, delay between consecutive reset releases.
REQ-005 The module SHALL have port aclk, input, 1, the single clock.
REQ-006 The module SHALL have port areset_n, input, 1, asynchronous active-low reset.
REQ-007 The module SHALL have port locked, input, 1, filtered PLL lock indication, synchronous to aclk.
REQ-008 The module SHALL have port request, input, 1, synchronous active-high request to re-run the reset sequence.
REQ-009 The module SHALL have port reset_n, output, OUTPUTS, active-low resets; bit 0 is released first.
REQ-010 The module SHALL have port ready, output, 1, high when all reset_n bits are released.

Function
REQ-011 The module SHALL derive STABLE_CYCLES = max(1, ceil(LOCK_STABLE_NS*CLOCK_FREQUENCY_HZ/1e9)) and STEP_CYCLES = max(1, ceil(STEP_DELAY_NS*CLOCK_FREQUENCY_HZ/1e9)), using 64-bit elaboration arithmetic.
REQ-012 The module SHALL size its counters to $clog2(max(STABLE_CYCLES, STEP_CYCLES)+1) bits and its release index to $clog2(OUTPUTS+1) bits; counters SHALL never wrap.
REQ-013 The module SHALL implement the FSM states WAIT_LOCK, STABLE, RELEASE and READY, with all outputs registered.
REQ-014 WAIT_LOCK: all reset_n=0 and ready=0; locked=1 and request=0 at edge E0 SHALL move the FSM to STABLE, with the stable count taken as 1.
REQ-015 STABLE: the FSM SHALL leave STABLE at edge E0+STABLE_CYCLES-1 if locked=1 and request=0 were sampled at every edge from E0; it SHALL then enter RELEASE with release index 0.
REQ-016 RELEASE: reset_n[k] SHALL rise at edge E0+STABLE_CYCLES-1+(k+1)*STEP_CYCLES, and released bits SHALL stay high.
REQ-017 After reset_n[OUTPUTS-1] rises, the FSM SHALL enter READY and ready SHALL rise one edge later.
REQ-018 READY: the FSM SHALL hold reset_n all ones and ready=1.
REQ-019 Abort: locked=0 or request=1 sampled in STABLE, RELEASE or READY SHALL, at that same edge, drive reset_n to all zeros, drive ready=0, clear the counters and move the FSM to WAIT_LOCK.
REQ-020 The module SHALL stay in WAIT_LOCK while request=1, regardless of locked.
REQ-021 When locked falls and request rises in the same cycle, the module SHALL perform a single abort, identical to REQ-019.
REQ-022 A locked glitch shorter than STABLE_CYCLES during STABLE SHALL restart the stable count from zero; the module SHALL never partially release resets.
REQ-023 When OUTPUTS=1, the FSM SHALL pass from RELEASE to READY after one step.

Reset
REQ-024 While areset_n=0, the module SHALL asynchronously force reset_n to all zeros, ready=0, the FSM to WAIT_LOCK, and counters and index to 0.
REQ-025 The module SHALL synchronize areset_n deassertion internally with a 2-flop synchronizer, so the FSM runs from the 3rd aclk edge after areset_n rises; assertion SHALL remain asynchronous.
REQ-026 An areset_n assertion mid-sequence SHALL behave identically to REQ-024, with no partial outputs held.

Verification
Bench parameters: CLOCK_FREQUENCY_HZ=100_000_000, LOCK_STABLE_NS=50 (5 cycles), STEP_DELAY_NS=30 (3 cycles), OUTPUTS=3.
REQ-027 The bench SHALL cover nominal sequencing: locked=1 from edge 10 -> reset_n[0] rises at edge 17, reset_n[1] at 20, reset_n[2] at 23, ready at 24.
REQ-028 The bench SHALL cover a lock glitch: locked=1 from edge 10, 0 at edge 12, 1 from edge 13 -> reset_n[0] rises at edge 20 and ready at 27.
REQ-029 The bench SHALL cover loss of lock in READY: locked drops at edge 40 -> reset_n=000 and ready=0 after edge 40; locked=1 again at edge 45 -> reset_n[0] rises at edge 52.
REQ-030 The bench SHALL cover a request in RELEASE: request=1 for edges 18..19 with locked held high -> reset_n=000 after edge 18; the FSM re-enters STABLE at edge 20 and reset_n[0] rises at edge 27.
REQ-031 The bench SHALL cover asynchronous reset mid-sequence: areset_n=0 between edges 21 and 22 -> reset_n=000 and ready=0 immediately; after release, the sequence restarts per REQ-025.
REQ-032 The bench SHALL cover the OUTPUTS=1 build: locked=1 from edge 10 -> reset_n rises at edge 17 and ready at 18.
